ser_frame_deser: RTL and testbench
==================================

# ser_frame_deser

Framed serial-to-parallel deserializer that consumes the registered serial bit from the upstream D flip-flop stage (async reset/preset flop driving `s_in`). It hunts for a sync pattern, then assembles the following `FRAME_LEN` words of `W` bits each and presents each word on a valid/ready output port. It returns to hunting after every frame. Drops are flagged and counted.

## Interface
- `W`, 8, word width in bits (≥2).
- `SYNC`, 8'hA5, W-bit sync pattern; compared MSB-first.
- `FRAME_LEN`, 4, data words per frame after sync (≥1).
- `clk`  in  1  clock; all state updates on posedge.
- `ret`  in  1  reset; asynchronous, active-low.
- `s_in`  in  1  serial data bit.
- `s_en`  in  1  `s_in` is valid this cycle.
- `resync`  in  1  synchronous request to drop the frame and hunt again.
- `par_data`  out  W  assembled word.
- `par_valid`  out  1  `par_data` holds an untaken word.
- `par_ready`  in  1  downstream accepts the word.
- `locked`  out  1  high while in SHIFT.
- `drop`  out  1  one-cycle pulse when a completed word is discarded.
- `drop_cnt`  out  4  saturating count of dropped words.

## Operation
- States: HUNT, SHIFT.
  - Reset state is HUNT.
  - Registers: `sh[W-1:0]`, `fill` (0..W), `bitc` (0..W-1), `wordc` (0..FRAME_LEN-1).
- Shift rule (both states, when `s_en`=1): `sh <= {sh[W-2:0], s_in}`. The first received bit ends up as the MSB.
- HUNT:
  - `fill` increments per bit and saturates at W.
  - When the post-shift `sh` equals SYNC and the post-shift `fill` equals W, go to SHIFT with `bitc`=0 and `wordc`=0.
  - Overlapping patterns are allowed: the match is tested on every bit.
- SHIFT:
  - `bitc` increments per bit.
  - On the bit where `bitc`=W-1, the word completes: the post-shift `sh` is the word, and `bitc` wraps to 0.
  - On word completion, `wordc` increments. If `wordc` was FRAME_LEN-1, go to HUNT.
- Entering HUNT, by any path: `sh`<=0, `fill`<=0, `bitc`<=0, `wordc`<=0.
- Output holding register:
  - On word completion, load `par_data` and set `par_valid` if the slot is free this cycle. The slot is free if `par_valid`=0, or if `par_valid`=1 and `par_ready`=1.
  - Otherwise discard the new word: pulse `drop`, increment `drop_cnt` (it saturates at 15), and leave `par_data` unchanged.
  - If a word is accepted and a new word completes in the same cycle, load the new word and keep `par_valid`=1. This is not a drop.
  - When accepted with no new word, `par_valid`<=0. `par_data` keeps its last value.
- `resync`=1 has priority over `s_en`: the state goes to HUNT, and the bit presented that cycle is ignored. `par_valid`, `par_data` and `drop_cnt` are not affected.
- `s_en`=0: no register changes except handshake clearing of `par_valid`.

## Timing
- Reset (`ret`=0, takes effect immediately, independent of `clk`):
  - `par_data`=0, `par_valid`=0, `locked`=0, `drop`=0, `drop_cnt`=0.
  - State HUNT, all counters and `sh` at 0.
  - Reset mid-frame discards the partial word and any pending output.
- Latency: `par_valid` and the word are visible after the same edge that samples the last bit of the word (zero extra cycles).
- `locked` rises after the edge that completes SYNC. It falls after the edge that completes the last word of the frame, or after the edge that samples `resync`.
- `drop` is high for exactly one cycle, after the offending edge.
- Minimum stream length per frame: W×(FRAME_LEN+1) valid bits.

## Structure
- Shared package `ser_pkg` holds:
  - the state enum (HUNT=1'b0, SHIFT=1'b1);
  - default constants `SER_W`=8, `SER_SYNC`=8'hA5, `SER_FRAME_LEN`=4;
  - the `DROP_CNT_MAX`=15 constant.
- One sub-module, `ser_shreg`: a W-bit shift register with enable and synchronous clear, whose parallel output is used by the match logic and the word load.
- The FSM, counters and output slot live in the top module.

## Test plan
- Reset: hold `ret`=0 and toggle `clk` 3 times → all outputs 0, `locked`=0. Assert `ret`=0 asynchronously mid-frame → outputs clear with no clock edge.
- Basic frame, with `par_ready`=1 and continuous `s_en`:
  - Send bits 1010_0101, then words 8'h3C, 8'hFF, 8'h00, 8'h81 MSB-first.
  - Required: `locked` goes 1 after the 8th bit; `par_valid` pulses with 8'h3C, 8'hFF, 8'h00, 8'h81, each after the last bit of its word; `locked`=0 after 8'h81.
- False/overlapping sync:
  - Stream 0_1010_0101 after reset → lock occurs after the 9th bit, not earlier.
  - Stream 1010_010 followed by `resync` → no lock.
- Backpressure:
  - With `par_ready`=0, send 2 words → the first is held, `drop` pulses once, `drop_cnt`=1.
  - Raise `par_ready` on the same cycle the third word completes → 8'h(third) is loaded, `par_valid` stays 1, no drop.
  - Force 20 drops → `drop_cnt` saturates at 15.
- Gaps: insert random `s_en`=0 cycles between bits → words and values are identical to the basic-frame case.
- Resync mid-word: assert `resync` after 3 bits of word 2 → `locked`=0 next cycle, that bit is ignored, no partial word is output, and a subsequent SYNC relocks.

Source files
------------

// File: rtl/ser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ser_pkg : shared types and default constants for the framed deserializer   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ser_pkg;

   typedef enum logic {
      HUNT  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam int         SER_W         = 8;
   localparam logic [7:0] SER_SYNC      = 8'hA5;
   localparam int         SER_FRAME_LEN = 4;
   localparam logic [3:0] DROP_CNT_MAX  = 4'd15;

endpackage
`default_nettype wire

// File: rtl/ser_shreg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ser_shreg : W-bit MSB-first shift register, enable + synchronous clear     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ser_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic         d_i,
   output logic [W-1:0] nxt_o
);

   logic [W-1:0] sh_q;
   logic         unused_msb;

   // Consumers need the value as it will be after this bit, so the oldest
   // bit is never read; it only exists to hold a full W-bit word.
   assign nxt_o      = {sh_q[W-2:0], d_i};
   assign unused_msb = sh_q[W-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q <= '0;
      end else if (clr_i) begin
         sh_q <= '0;
      end else if (en_i) begin
         sh_q <= nxt_o;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ser_frame_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ser_frame_deser : sync-hunting framed serial-to-parallel deserializer      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ser_frame_deser
   import ser_pkg::*;
#(
   parameter int          W         = SER_W,
   parameter logic [W-1:0] SYNC     = W'(SER_SYNC),
   parameter int          FRAME_LEN = SER_FRAME_LEN
) (
   input  logic         clk,
   input  logic         ret,
   input  logic         s_in,
   input  logic         s_en,
   input  logic         resync,
   output logic [W-1:0] par_data,
   output logic         par_valid,
   input  logic         par_ready,
   output logic         locked,
   output logic         drop,
   output logic [3:0]   drop_cnt
);

   localparam int FILL_W  = $clog2(W + 1);
   localparam int BITC_W  = $clog2(W);
   localparam int WORDC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(W);
   localparam logic [BITC_W-1:0]  BITC_LAST  = BITC_W'(W - 1);
   localparam logic [WORDC_W-1:0] WORDC_LAST = WORDC_W'(FRAME_LEN - 1);

   state_e              state_q, state_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [BITC_W-1:0]   bitc_q, bitc_d;
   logic [WORDC_W-1:0]  wordc_q, wordc_d;
   logic [W-1:0]        par_data_q, par_data_d;
   logic                par_valid_q, par_valid_d;
   logic                drop_q, drop_d;
   logic [3:0]          drop_cnt_q, drop_cnt_d;

   logic [W-1:0]        sh_nxt;
   logic                sh_en;
   logic                sh_clr;
   logic                word_done;
   logic                slot_free;

   ser_shreg #(
      .W (W)
   ) u_shreg (
      .clk   (clk),
      .rst_n (ret),
      .en_i  (sh_en),
      .clr_i (sh_clr),
      .d_i   (s_in),
      .nxt_o (sh_nxt)
   );

   always_ff @(posedge clk or negedge ret) begin
      if (!ret) begin
         state_q     <= HUNT;
         fill_q      <= '0;
         bitc_q      <= '0;
         wordc_q     <= '0;
         par_data_q  <= '0;
         par_valid_q <= 1'b0;
         drop_q      <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         bitc_q      <= bitc_d;
         wordc_q     <= wordc_d;
         par_data_q  <= par_data_d;
         par_valid_q <= par_valid_d;
         drop_q      <= drop_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Framing FSM: resync outranks s_en, and every path back to HUNT wipes
   // the shift register and all counters so the next hunt starts clean.
   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      bitc_d    = bitc_q;
      wordc_d   = wordc_q;
      sh_en     = 1'b0;
      sh_clr    = 1'b0;
      word_done = 1'b0;

      if (resync) begin
         state_d = HUNT;
         fill_d  = '0;
         bitc_d  = '0;
         wordc_d = '0;
         sh_clr  = 1'b1;
      end else if (s_en) begin
         sh_en = 1'b1;
         if (state_q == HUNT) begin
            fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
            if ((sh_nxt == SYNC) && (fill_d == FILL_FULL)) begin
               state_d = SHIFT;
               bitc_d  = '0;
               wordc_d = '0;
            end
         end else begin
            if (bitc_q == BITC_LAST) begin
               word_done = 1'b1;
               bitc_d    = '0;
               if (wordc_q == WORDC_LAST) begin
                  state_d = HUNT;
                  fill_d  = '0;
                  wordc_d = '0;
                  sh_clr  = 1'b1;
               end else begin
                  wordc_d = wordc_q + 1'b1;
               end
            end else begin
               bitc_d = bitc_q + 1'b1;
            end
         end
      end
   end

   // Single-entry output slot; a word completing while the slot is still
   // occupied and not being taken is discarded rather than stalling input.
   always_comb begin
      slot_free   = !par_valid_q || par_ready;
      par_data_d  = par_data_q;
      par_valid_d = par_valid_q;
      drop_d      = 1'b0;
      drop_cnt_d  = drop_cnt_q;

      if (word_done) begin
         if (slot_free) begin
            par_data_d  = sh_nxt;
            par_valid_d = 1'b1;
         end else begin
            drop_d = 1'b1;
            if (drop_cnt_q != DROP_CNT_MAX) begin
               drop_cnt_d = drop_cnt_q + 1'b1;
            end
         end
      end else if (par_valid_q && par_ready) begin
         par_valid_d = 1'b0;
      end
   end

   assign par_data  = par_data_q;
   assign par_valid = par_valid_q;
   assign locked    = (state_q == SHIFT);
   assign drop      = drop_q;
   assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ser_frame_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ser_frame_deser : directed vector bench for ser_frame_deser             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ser_frame_deser;

   logic       clk = 1'b0;
   logic       ret;
   logic       s_in;
   logic       s_en;
   logic       resync;
   logic       par_ready;
   logic [7:0] par_data;
   logic       par_valid;
   logic       locked;
   logic       drop;
   logic [3:0] drop_cnt;

   always #5 clk = ~clk;

   ser_frame_deser #(
      .W         (8),
      .SYNC      (8'hA5),
      .FRAME_LEN (4)
   ) dut (
      .clk       (clk),
      .ret       (ret),
      .s_in      (s_in),
      .s_en      (s_en),
      .resync    (resync),
      .par_data  (par_data),
      .par_valid (par_valid),
      .par_ready (par_ready),
      .locked    (locked),
      .drop      (drop),
      .drop_cnt  (drop_cnt)
   );

   typedef struct {
      logic       s_in;
      logic       s_en;
      logic       resync;
      logic       rdy;
      logic       e_lk;
      logic       e_v;
      logic [7:0] e_d;
      logic       e_dr;
      logic [3:0] e_cnt;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic si, input logic se, input logic rs, input logic rdy,
                       input logic lk, input logic v, input logic [7:0] d,
                       input logic dr, input logic [3:0] c);
      vec_t t;
      t.s_in = si; t.s_en = se; t.resync = rs; t.rdy = rdy;
      t.e_lk = lk; t.e_v = v; t.e_d = d; t.e_dr = dr; t.e_cnt = c;
      vq.push_back(t);
   endtask

   // Eight MSB-first bits; expectations are constant over bits 0..6 and
   // given separately for the edge that samples the last bit.
   task automatic push_byte(input logic [7:0] b, input logic rdy, input logic rdy_last,
                            input logic lk_mid, input logic lk_end,
                            input logic v_mid, input logic [7:0] d_mid,
                            input logic v_end, input logic [7:0] d_end,
                            input logic dr_end, input logic [3:0] c_mid,
                            input logic [3:0] c_end, input bit gaps);
      for (int i = 7; i >= 0; i--) begin
         if (gaps && ($urandom_range(0, 2) == 0))
            push(1'($urandom_range(0, 1)), 1'b0, 1'b0, rdy, lk_mid, v_mid, d_mid, 1'b0, c_mid);
         if (i > 0)
            push(b[i], 1'b1, 1'b0, rdy, lk_mid, v_mid, d_mid, 1'b0, c_mid);
         else
            push(b[0], 1'b1, 1'b0, rdy_last, lk_end, v_end, d_end, dr_end, c_end);
      end
   endtask

   task automatic push_frame_rdy(input logic [7:0] w0, input logic [7:0] w1,
                                 input logic [7:0] w2, input logic [7:0] w3, input bit gaps);
      logic [7:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      push_byte(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0, gaps);
      for (int k = 0; k < 4; k++)
         push_byte(w[k], 1'b1, 1'b1, 1'b1, (k != 3), 1'b0, 8'h00, 1'b1, w[k], 1'b0,
                   4'd0, 4'd0, gaps);
      push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < vq.size(); i++) begin
         s_in      = vq[i].s_in;
         s_en      = vq[i].s_en;
         resync    = vq[i].resync;
         par_ready = vq[i].rdy;
         @(posedge clk);
         #1;
         chk($sformatf("%s[%0d] locked", tag, i), 8'(locked), 8'(vq[i].e_lk));
         chk($sformatf("%s[%0d] par_valid", tag, i), 8'(par_valid), 8'(vq[i].e_v));
         if (vq[i].e_v)
            chk($sformatf("%s[%0d] par_data", tag, i), par_data, vq[i].e_d);
         chk($sformatf("%s[%0d] drop", tag, i), 8'(drop), 8'(vq[i].e_dr));
         chk($sformatf("%s[%0d] drop_cnt", tag, i), 8'(drop_cnt), 8'(vq[i].e_cnt));
      end
      vq.delete();
      s_en   = 1'b0;
      resync = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      ret = 1'b0; s_in = 1'b0; s_en = 1'b0; resync = 1'b0; par_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, " rst par_data"}, par_data, 8'h00);
      chk({tag, " rst par_valid"}, 8'(par_valid), 8'h00);
      chk({tag, " rst locked"}, 8'(locked), 8'h00);
      chk({tag, " rst drop"}, 8'(drop), 8'h00);
      chk({tag, " rst drop_cnt"}, 8'(drop_cnt), 8'h00);
      ret = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] ovl;
      logic [6:0] fls;
      logic [3:0] c, nc;
      logic [7:0] b;

      // Basic frame, continuous s_en
      do_reset("basic");
      push_frame_rdy(8'h3C, 8'hFF, 8'h00, 8'h81, 1'b0);
      run_table("basic");

      // Same frame with idle cycles sprinkled between bits
      do_reset("gaps");
      push_frame_rdy(8'h3C, 8'hFF, 8'h00, 8'h81, 1'b1);
      run_table("gaps");

      // Leading zero before the sync: lock only on the ninth bit
      do_reset("ovl");
      ovl = 9'b0_1010_0101;
      for (int i = 8; i >= 0; i--)
         push(ovl[i], 1'b1, 1'b0, 1'b1, (i == 0), 1'b0, 8'h00, 1'b0, 4'd0);
      run_table("ovl");

      // Partial sync then resync: the resync bit is dropped, a fresh sync relocks
      do_reset("false");
      fls = 7'b101_0010;
      for (int i = 6; i >= 0; i--)
         push(fls[i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      push_byte(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0);
      run_table("false");

      // Backpressure: hold, drop, same-cycle take+load, then frame end
      do_reset("bp");
      push_byte(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0);
      push_byte(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 4'd0, 4'd0, 1'b0);
      push_byte(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 4'd0, 4'd1, 1'b0);
      push_byte(8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h33, 1'b0, 4'd1, 4'd1, 1'b0);
      push_byte(8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h44, 1'b0, 4'd1, 4'd1, 1'b0);
      push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1);
      run_table("bp");

      // Drop counter saturation: 23 discarded words across six frames
      do_reset("sat");
      c = 4'd0;
      for (int f = 0; f < 6; f++) begin
         push_byte(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, (f > 0), 8'h10, (f > 0), 8'h10, 1'b0,
                   c, c, 1'b0);
         for (int k = 0; k < 4; k++) begin
            b = 8'h10 + 8'(k);
            if (f == 0 && k == 0) begin
               push_byte(b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0,
                         c, c, 1'b0);
            end else begin
               nc = (c == 4'd15) ? 4'd15 : c + 4'd1;
               push_byte(b, 1'b0, 1'b0, 1'b1, (k != 3), 1'b1, 8'h10, 1'b1, 8'h10, 1'b1,
                         c, nc, 1'b0);
               c = nc;
            end
         end
      end
      run_table("sat");
      chk("sat final drop_cnt", 8'(drop_cnt), 8'd15);

      // Resync three bits into word 2, then relock on a new frame
      do_reset("rsm");
      push_byte(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0);
      push_byte(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 4'd0, 4'd0, 1'b0);
      push(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
      push(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
      push(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
      push(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      push_frame_rdy(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
      run_table("rsm");

      // Asynchronous reset mid-frame with a held word and a nonzero drop count
      do_reset("async");
      push_byte(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0);
      push_byte(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 4'd0, 4'd0, 1'b0);
      push_byte(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 4'd0, 4'd1, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 4'd1);
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 4'd1);
      run_table("async");
      #2;
      ret = 1'b0;
      #1;
      chk("async par_data", par_data, 8'h00);
      chk("async par_valid", 8'(par_valid), 8'h00);
      chk("async locked", 8'(locked), 8'h00);
      chk("async drop_cnt", 8'(drop_cnt), 8'h00);
      @(posedge clk);
      #1;
      ret = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
